// File: rtl/scan_chain_driver.sv
// Host-side scan chain initiator: streams bytes onto sc_se/sc_sc and captures sc_so
// into an output byte stream, so configuration load and readback share one pass.
module scan_chain_driver #(
  parameter int CHAIN_LEN = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       sc_se,
  output logic       sc_sc,
  input  logic       sc_so
);

  localparam int NBYTES = (CHAIN_LEN + 7) / 8;
  localparam int CW     = $clog2(CHAIN_LEN + 1);
  localparam int BW     = $clog2(NBYTES + 1);

  // IDLE: wait for start | PREFETCH: take first byte | SHIFT: chain moving | DRAIN: flush output, pulse done
  typedef enum logic [1:0] {IDLE, PREFETCH, SHIFT, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [BW-1:0]   in_cnt_q, in_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      next_q, next_d;
  logic            next_vld_q, next_vld_d;
  logic [7:0]      cap_q, cap_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            err_q, err_d;

  logic            in_ready_c;
  logic            in_hs;
  logic            done_c;
  logic            last;
  logic            underrun;
  logic            overrun;
  logic [7:0]      cap_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      in_cnt_q    <= '0;
      shreg_q     <= '0;
      next_q      <= '0;
      next_vld_q  <= 1'b0;
      cap_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      in_cnt_q    <= in_cnt_d;
      shreg_q     <= shreg_d;
      next_q      <= next_d;
      next_vld_q  <= next_vld_d;
      cap_q       <= cap_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    in_cnt_d    = in_cnt_q;
    shreg_d     = shreg_q;
    next_d      = next_q;
    next_vld_d  = next_vld_q;
    cap_d       = cap_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    done_c      = 1'b0;
    underrun    = 1'b0;
    overrun     = 1'b0;
    cap_nx      = cap_q;
    last        = (cnt_q == CW'(CHAIN_LEN - 1));

    // in_ready is built from registers only so it never follows in_valid
    in_ready_c = 1'b0;
    if (state_q == PREFETCH) begin
      in_ready_c = 1'b1;
    end else if (state_q == SHIFT) begin
      in_ready_c = !next_vld_q && (in_cnt_q < BW'(NBYTES));
    end
    in_hs = in_valid && in_ready_c;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = PREFETCH;
          err_d      = 1'b0;
          cnt_d      = '0;
          bit_d      = '0;
          in_cnt_d   = '0;
          cap_d      = '0;
          next_vld_d = 1'b0;
        end
      end
      PREFETCH: begin
        if (in_hs) begin
          shreg_d  = in_data;
          in_cnt_d = in_cnt_q + BW'(1);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        cnt_d          = cnt_q + CW'(1);
        bit_d          = bit_q + 3'd1;
        shreg_d        = {1'b0, shreg_q[7:1]};
        cap_nx[bit_q]  = sc_so;
        cap_d          = cap_nx;

        if ((bit_q == 3'd7) && !last) begin
          if (next_vld_q) begin
            shreg_d    = next_q;
            next_vld_d = 1'b0;
          end else if (in_hs) begin
            shreg_d  = in_data;
            in_cnt_d = in_cnt_q + BW'(1);
          end else begin
            underrun = 1'b1;
          end
        end else if (in_hs) begin
          next_d     = in_data;
          next_vld_d = 1'b1;
          in_cnt_d   = in_cnt_q + BW'(1);
        end

        // cap is cleared after each move, which zero-pads a short final byte
        if ((bit_q == 3'd7) || last) begin
          if (!out_valid_q || out_ready) begin
            out_data_d  = cap_nx;
            out_valid_d = 1'b1;
            cap_d       = '0;
          end else begin
            overrun = 1'b1;
          end
        end

        if (underrun || overrun) begin
          state_d     = DRAIN;
          err_d       = 1'b1;
          out_valid_d = 1'b0;
          next_vld_d  = 1'b0;
        end else if (last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!out_valid_q) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_c;
  assign err       = err_q;
  assign in_ready  = in_ready_c;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign sc_se     = (state_q == SHIFT);
  assign sc_sc     = (state_q == SHIFT) && shreg_q[0];

endmodule

// File: doc/scan_chain_driver.md
Name: scan_chain_driver

Overview:
- Host-side initiator for the rotfpga2 grid scan chain.
- Serialises a byte stream onto the grid's scan-enable/scan-in pins and deserialises the scan-out pin into a byte stream. Configuration load and state readback therefore happen in the same pass.
- Sits in the companion test/loader design. Its sc_se, sc_sc and sc_so connect to the grid's uio_in[0], uio_in[1] and uio_out[7].

Parameters:
- CHAIN_LEN, 128, number of flops in the scan chain. Must be at least 1; need not be a multiple of 8.
- NBYTES, derived as ceil(CHAIN_LEN/8), bytes consumed and produced per pass. Not overridable.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle pulse that begins a pass; only honoured in IDLE
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse at the end of a pass, normal or aborted
- err  output  1  sticky abort flag; cleared by the next accepted start
- in_data  input  8  chain data, LSB first
- in_valid  input  1  in_data valid
- in_ready  output  1  driver can accept a byte
- out_data  output  8  captured chain data, LSB first
- out_valid  output  1  out_data valid
- out_ready  input  1  sink accepts out_data
- sc_se  output  1  scan enable to the grid
- sc_sc  output  1  scan data to the grid
- sc_so  input  1  scan data from the grid

Behaviour:
- Reset values: every output is 0 and every register is cleared. Reset mid-pass aborts immediately; sc_se drops asynchronously and no done pulse is issued.
- States: IDLE, PREFETCH, SHIFT, DRAIN.
- IDLE:
  - busy=0, in_ready=0, sc_se=0, sc_sc=0.
  - start moves to PREFETCH, clears err and zeroes the bit counter. The counter width is clog2(CHAIN_LEN+1).
  - start outside IDLE is ignored.
- PREFETCH:
  - in_ready=1, sc_se=0.
  - The first handshake loads the byte into the shift register and moves to SHIFT.
- SHIFT:
  - sc_se=1 and sc_sc=shreg[0] every cycle. Every clock edge shifts one bit, and the chain never pauses with sc_se high.
  - On each edge, sc_so is sampled (the grid's pre-shift last-flop value) into a capture register at bit position (count mod 8).
  - A one-byte next register prefetches input. in_ready=1 while it is empty and input bytes remain (fewer than NBYTES accepted).
  - At the edge that shifts bit 7 of a byte, with more bits remaining, the next byte loads into shreg. A handshake in that same cycle bypasses directly into shreg.
  - Underrun: the next register is empty and there is no bypass handshake. Set err and abort.
- Output path:
  - On the edge capturing the 8th bit of a byte, or the final chain bit, the capture register moves to out_data and out_valid rises.
  - The final byte is zero-padded in its high bits when CHAIN_LEN mod 8 ≠ 0.
  - The move is legal if out_valid=0, or out_valid=1 with out_ready=1 in that cycle.
  - Overrun: the move is not legal. Set err and abort.
  - out_valid clears on a handshake unless a new byte is loaded in the same cycle.
- Completion:
  - After the edge shifting bit CHAIN_LEN-1, go to DRAIN with sc_se=0 in the next cycle.
  - DRAIN waits until out_valid=0, then pulses done for one cycle and returns to IDLE.
  - If out_valid=0 on entry, done is asserted in the first DRAIN cycle.
- Abort (underrun or overrun):
  - Next cycle: sc_se=0, out_valid=0, next register discarded, err=1, done pulses, return to IDLE.
  - Unconsumed source bytes are left untouched.
- Handshake signals: in_ready and out_valid never depend combinationally on in_valid or out_ready.

Test Plan:
- CHAIN_LEN=16; bytes 0xA5, 0x3C with in_valid always high and out_ready always high; sc_so looped from sc_sc through a 16-flop model preloaded with 0x1234.
  - Required: sc_se high for exactly 16 cycles and sc_sc sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
  - Required: out bytes 0x34, 0x12; done pulses once with err=0; model then holds 0x3CA5.
- Same setup with CHAIN_LEN=12 and bytes 0xFF, 0x0F.
  - Required: 12 shift cycles; second out byte has bits [7:4]=0; exactly 2 input and 2 output handshakes.
- Withhold the second in_valid past the 8th shift edge.
  - Required: err=1, sc_se low the next cycle, a single done pulse, and in_ready=0 afterwards.
- Hold out_ready low throughout.
  - Required: the first out byte is held valid; at the edge completing the 2nd byte, err=1 and out_valid drops.
- Pulse start during SHIFT.
  - Required: ignored, pass unaffected. Then assert rst_n=0 mid-pass: sc_se, busy and out_valid go to 0 without waiting for a clock, and there is no done pulse.
